// File: rtl/ocp3_nic_multi_seq_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : ocp3_nic_multi_seq_pkg
//  Description : Slot state encodings and default sequencing timings for the
//                OCP3 NIC multi-slot power/reset sequencer.
//  Revision    : 1.0 - initial release
// ============================================================================
package ocp3_nic_multi_seq_pkg;

    // Encodings are visible to the BMC through oFSM_STATE and must not move.
    typedef enum logic [3:0] {
        ST_MAIN     = 4'h0,
        ST_MAIN_DLY = 4'h1,
        ST_MAIN_OFF = 4'h2,
        ST_AUX_ON   = 4'h3,
        ST_AUX_WAIT = 4'h5,
        ST_IDLE     = 4'h7,
        ST_AUX_RAMP = 4'h9,
        ST_FAULT    = 4'hF
    } slotState_t;

    localparam int c_T_PRSNT_MS  = 105;
    localparam int c_T_AUX_EN_MS = 21;
    localparam int c_T_PERST_MS  = 1050;
    localparam int c_T_OFF_MS    = 1;
    localparam int c_SEQ_TO_MS   = 1000;
    localparam int c_STAGGER_MS  = 10;

    // States in which loss of NIC PWRGD or P3V3_AUX counts as a runtime fault.
    function automatic logic runFltArmed(slotState_t s);
        return (s == ST_AUX_ON) || (s == ST_MAIN_DLY) || (s == ST_MAIN) || (s == ST_MAIN_OFF);
    endfunction

endpackage : ocp3_nic_multi_seq_pkg
`default_nettype wire

// File: rtl/ocp3_nic_multi_seq_if.sv
`default_nettype none
// ============================================================================
//  Module      : ocp3_nic_multi_seq_if
//  Description : Board-side bus of the OCP3 NIC sequencer: per-slot status in,
//                rail enables, PERST_N, state and fault flags out.
//  Revision    : 1.0 - initial release
// ============================================================================
interface ocp3_nic_multi_seq_if #(
    parameter int NUM_SLOTS = 2
);
    logic                     iTick_1ms;
    logic [NUM_SLOTS-1:0]     iPRSNT_N;
    logic [NUM_SLOTS-1:0]     iPG_AUX;
    logic [NUM_SLOTS-1:0]     iPWRGD_EDGE;
    logic [NUM_SLOTS-1:0]     iPWRGD_NIC;
    logic                     iPWR_EN_DEV;
    logic                     iFLT_CLR;
    logic [NUM_SLOTS-1:0]     oAUX_EN;
    logic [NUM_SLOTS-1:0]     oMAIN_EN;
    logic [NUM_SLOTS-1:0]     oPERST_N;
    logic [4*NUM_SLOTS-1:0]   oFSM_STATE;
    logic [NUM_SLOTS-1:0]     oSEQ_FLT;
    logic [NUM_SLOTS-1:0]     oRUN_FLT;

    modport master (
        output iTick_1ms, iPRSNT_N, iPG_AUX, iPWRGD_EDGE, iPWRGD_NIC, iPWR_EN_DEV, iFLT_CLR,
        input  oAUX_EN, oMAIN_EN, oPERST_N, oFSM_STATE, oSEQ_FLT, oRUN_FLT
    );

    modport slave (
        input  iTick_1ms, iPRSNT_N, iPG_AUX, iPWRGD_EDGE, iPWRGD_NIC, iPWR_EN_DEV, iFLT_CLR,
        output oAUX_EN, oMAIN_EN, oPERST_N, oFSM_STATE, oSEQ_FLT, oRUN_FLT
    );

endinterface : ocp3_nic_multi_seq_if
`default_nettype wire

// File: rtl/ocp3_nic_slot_fsm.sv
`default_nettype none
// ============================================================================
//  Module      : ocp3_nic_slot_fsm
//  Description : One OCP3 NIC slot: power/reset FSM, delay and timeout
//                counters, sticky sequencing/runtime fault flags.
//  Revision    : 1.0 - initial release
// ============================================================================
module ocp3_nic_slot_fsm
    import ocp3_nic_multi_seq_pkg::*;
#(
    parameter int T_PRSNT_MS     = c_T_PRSNT_MS,
    parameter int T_AUX_EN_MS    = c_T_AUX_EN_MS,
    parameter int T_PERST_MS     = c_T_PERST_MS,
    parameter int T_OFF_MS       = c_T_OFF_MS,
    parameter int SEQ_TO_MS      = c_SEQ_TO_MS,
    parameter int STAGGER_DLY_MS = 0
) (
    input  logic       iClk,
    input  logic       iRst_n,
    input  logic       iTick_1ms,
    input  logic       iPrsntN,
    input  logic       iPgAux,
    input  logic       iPwrgdEdge,
    input  logic       iPwrgdNic,
    input  logic       iPwrEnDev,
    input  logic       iFltClr,
    output logic       oAuxEn,
    output logic       oMainEn,
    output logic       oPerstN,
    output logic [3:0] oState,
    output logic       oSeqFlt,
    output logic       oRunFlt
);

    slotState_t  r_state, w_stateNext;
    logic [15:0] r_dly, w_dlyNext;
    logic [15:0] r_to, w_toNext;
    logic        r_auxEn, w_auxEnNext;
    logic        r_mainEn, w_mainEnNext;
    logic        r_perstN, w_perstNNext;
    logic        r_seqFlt, r_runFlt;
    logic        w_seqSet, w_runSet;
    logic        w_dlyReload;
    logic        w_dlyDone, w_toDone;

    function automatic logic [15:0] dlyLoad(slotState_t s);
        case (s)
            ST_IDLE:     return 16'(T_PRSNT_MS);
            ST_AUX_WAIT: return 16'(T_AUX_EN_MS);
            ST_AUX_ON:   return 16'(STAGGER_DLY_MS);
            ST_MAIN_DLY: return 16'(T_PERST_MS);
            ST_MAIN_OFF: return 16'(T_OFF_MS);
            default:     return 16'd0;
        endcase
    endfunction

    assign w_dlyDone = (r_dly == 16'd0);
    assign w_toDone  = (r_to == 16'd0);

    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            r_state  <= ST_IDLE;
            r_dly    <= 16'(T_PRSNT_MS);
            r_to     <= 16'(SEQ_TO_MS);
            r_auxEn  <= 1'b0;
            r_mainEn <= 1'b0;
            r_perstN <= 1'b0;
            r_seqFlt <= 1'b0;
            r_runFlt <= 1'b0;
        end else begin
            r_state  <= w_stateNext;
            r_dly    <= w_dlyNext;
            r_to     <= w_toNext;
            r_auxEn  <= w_auxEnNext;
            r_mainEn <= w_mainEnNext;
            r_perstN <= w_perstNNext;
            // A fault raised in the same cycle as the clear pulse survives it.
            r_seqFlt <= w_seqSet | (r_seqFlt & ~iFltClr);
            r_runFlt <= w_runSet | (r_runFlt & ~iFltClr);
        end
    end

    always_comb begin
        w_stateNext  = r_state;
        w_auxEnNext  = r_auxEn;
        w_mainEnNext = r_mainEn;
        w_perstNNext = r_perstN;
        w_seqSet     = 1'b0;
        w_runSet     = 1'b0;
        w_dlyReload  = 1'b0;

        if (iPrsntN) begin
            w_stateNext  = ST_IDLE;
            w_auxEnNext  = 1'b0;
            w_mainEnNext = 1'b0;
            w_perstNNext = 1'b0;
            w_dlyReload  = 1'b1;
        end else if (runFltArmed(r_state) && (!iPwrgdNic || !iPgAux)) begin
            w_stateNext  = ST_FAULT;
            w_auxEnNext  = 1'b0;
            w_mainEnNext = 1'b0;
            w_perstNNext = 1'b0;
            w_runSet     = 1'b1;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (!iPgAux) begin
                        w_dlyReload = 1'b1;
                    end else if (w_dlyDone) begin
                        w_stateNext = ST_AUX_WAIT;
                    end
                end
                ST_AUX_WAIT: begin
                    if (!iPwrgdEdge && w_toDone) begin
                        w_stateNext = ST_FAULT;
                        w_seqSet    = 1'b1;
                    end else if (!iPwrgdEdge) begin
                        w_dlyReload = 1'b1;
                    end else if (w_dlyDone) begin
                        w_auxEnNext = 1'b1;
                        w_stateNext = ST_AUX_RAMP;
                    end
                end
                ST_AUX_RAMP: begin
                    if (iPwrgdNic) begin
                        w_stateNext = ST_AUX_ON;
                    end else if (w_toDone) begin
                        w_stateNext = ST_FAULT;
                        w_auxEnNext = 1'b0;
                        w_seqSet    = 1'b1;
                    end
                end
                ST_AUX_ON: begin
                    if (!iPwrEnDev) begin
                        w_dlyReload = 1'b1;
                    end else if (w_dlyDone) begin
                        w_mainEnNext = 1'b1;
                        w_stateNext  = ST_MAIN_DLY;
                    end
                end
                ST_MAIN_DLY: begin
                    if (!iPwrEnDev) begin
                        w_stateNext = ST_MAIN_OFF;
                    end else if (w_dlyDone) begin
                        w_perstNNext = 1'b1;
                        w_stateNext  = ST_MAIN;
                    end
                end
                ST_MAIN: begin
                    if (!iPwrEnDev) begin
                        w_perstNNext = 1'b0;
                        w_stateNext  = ST_MAIN_OFF;
                    end
                end
                ST_MAIN_OFF: begin
                    if (w_dlyDone) begin
                        w_mainEnNext = 1'b0;
                        w_stateNext  = ST_AUX_ON;
                    end
                end
                ST_FAULT: begin
                    if (iFltClr) begin
                        w_stateNext = ST_IDLE;
                    end
                end
                default: begin
                    w_stateNext  = ST_IDLE;
                    w_auxEnNext  = 1'b0;
                    w_mainEnNext = 1'b0;
                    w_perstNNext = 1'b0;
                end
            endcase
        end
    end

    // Both counters restart on any state change; the delay also restarts while its qualifier is low.
    always_comb begin
        w_dlyNext = r_dly;
        w_toNext  = r_to;
        if ((w_stateNext != r_state) || w_dlyReload) begin
            w_dlyNext = dlyLoad(w_stateNext);
        end else if (iTick_1ms && !w_dlyDone) begin
            w_dlyNext = r_dly - 16'd1;
        end
        if (w_stateNext != r_state) begin
            w_toNext = 16'(SEQ_TO_MS);
        end else if (iTick_1ms && !w_toDone) begin
            w_toNext = r_to - 16'd1;
        end
    end

    assign oAuxEn  = r_auxEn;
    assign oMainEn = r_mainEn;
    assign oPerstN = r_perstN;
    assign oState  = r_state;
    assign oSeqFlt = r_seqFlt;
    assign oRunFlt = r_runFlt;

    aPerstNeedsMain: assert property (@(posedge iClk) disable iff (!iRst_n) r_perstN |-> r_mainEn);
    aMainNeedsAux:   assert property (@(posedge iClk) disable iff (!iRst_n) r_mainEn |-> r_auxEn);

endmodule : ocp3_nic_slot_fsm
`default_nettype wire

// File: rtl/ocp3_nic_multi_seq.sv
`default_nettype none
// ============================================================================
//  Module      : ocp3_nic_multi_seq
//  Description : Power/reset sequencer for NUM_SLOTS OCP3 NIC slots with
//                staggered main enable and sticky fault reporting.
//  Revision    : 1.0 - initial release
// ============================================================================
module ocp3_nic_multi_seq
    import ocp3_nic_multi_seq_pkg::*;
#(
    parameter int NUM_SLOTS   = 2,
    parameter int T_PRSNT_MS  = c_T_PRSNT_MS,
    parameter int T_AUX_EN_MS = c_T_AUX_EN_MS,
    parameter int T_PERST_MS  = c_T_PERST_MS,
    parameter int T_OFF_MS    = c_T_OFF_MS,
    parameter int SEQ_TO_MS   = c_SEQ_TO_MS,
    parameter int STAGGER_MS  = c_STAGGER_MS
) (
    input  logic                 iClk,
    input  logic                 iRst_n,
    ocp3_nic_multi_seq_if.slave  bus
);

    logic [NUM_SLOTS-1:0]   w_auxEn;
    logic [NUM_SLOTS-1:0]   w_mainEn;
    logic [NUM_SLOTS-1:0]   w_perstN;
    logic [4*NUM_SLOTS-1:0] w_state;
    logic [NUM_SLOTS-1:0]   w_seqFlt;
    logic [NUM_SLOTS-1:0]   w_runFlt;

    // Slot k waits an extra k*STAGGER_MS to spread the main-rail inrush.
    for (genvar k = 0; k < NUM_SLOTS; k++) begin : g_slot
        ocp3_nic_slot_fsm #(
            .T_PRSNT_MS     (T_PRSNT_MS),
            .T_AUX_EN_MS    (T_AUX_EN_MS),
            .T_PERST_MS     (T_PERST_MS),
            .T_OFF_MS       (T_OFF_MS),
            .SEQ_TO_MS      (SEQ_TO_MS),
            .STAGGER_DLY_MS (k * STAGGER_MS)
        ) u_slot (
            .iClk       (iClk),
            .iRst_n     (iRst_n),
            .iTick_1ms  (bus.iTick_1ms),
            .iPrsntN    (bus.iPRSNT_N[k]),
            .iPgAux     (bus.iPG_AUX[k]),
            .iPwrgdEdge (bus.iPWRGD_EDGE[k]),
            .iPwrgdNic  (bus.iPWRGD_NIC[k]),
            .iPwrEnDev  (bus.iPWR_EN_DEV),
            .iFltClr    (bus.iFLT_CLR),
            .oAuxEn     (w_auxEn[k]),
            .oMainEn    (w_mainEn[k]),
            .oPerstN    (w_perstN[k]),
            .oState     (w_state[4*k +: 4]),
            .oSeqFlt    (w_seqFlt[k]),
            .oRunFlt    (w_runFlt[k])
        );
    end

    assign bus.oAUX_EN    = w_auxEn;
    assign bus.oMAIN_EN   = w_mainEn;
    assign bus.oPERST_N   = w_perstN;
    assign bus.oFSM_STATE = w_state;
    assign bus.oSEQ_FLT   = w_seqFlt;
    assign bus.oRUN_FLT   = w_runFlt;

endmodule : ocp3_nic_multi_seq
`default_nettype wire

// File: tb/tb_ocp3_nic_multi_seq.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ocp3_nic_multi_seq
//  Description : Directed, table-driven bench for the two-slot OCP3 NIC
//                sequencer (fast timings, 1 ms = 8 clocks).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_ocp3_nic_multi_seq;

    logic iClk   = 1'b0;
    logic iRst_n = 1'b1;

    always #250 iClk = ~iClk;

    ocp3_nic_multi_seq_if #(.NUM_SLOTS(2)) bus ();

    ocp3_nic_multi_seq #(
        .NUM_SLOTS   (2),
        .T_PRSNT_MS  (5),
        .T_AUX_EN_MS (2),
        .T_PERST_MS  (10),
        .T_OFF_MS    (1),
        .SEQ_TO_MS   (20),
        .STAGGER_MS  (3)
    ) dut (
        .iClk   (iClk),
        .iRst_n (iRst_n),
        .bus    (bus)
    );

    typedef struct {
        logic [1:0] prsntN;
        logic [1:0] pgAux;
        logic [1:0] edgeGood;
        logic [1:0] nic;
        logic       pwrEn;
        logic       fltClr;
        int         nClk;
        int         nMs;
        logic [7:0] st;
        logic [1:0] aux;
        logic [1:0] mainEn;
        logic [1:0] perst;
        logic [1:0] seq;
        logic [1:0] run;
    } vec_t;

    vec_t vecs[15];
    int   nChecks = 0;
    int   nFail   = 0;

    function automatic vec_t mk(logic [1:0] nic, logic pwrEn, logic fltClr, int nClk, int nMs,
                                logic [7:0] st, logic [1:0] aux, logic [1:0] mainEn,
                                logic [1:0] perst, logic [1:0] run);
        vec_t v;
        v.prsntN   = 2'b00;
        v.pgAux    = 2'b11;
        v.edgeGood = 2'b11;
        v.nic      = nic;
        v.pwrEn    = pwrEn;
        v.fltClr   = fltClr;
        v.nClk     = nClk;
        v.nMs      = nMs;
        v.st       = st;
        v.aux      = aux;
        v.mainEn   = mainEn;
        v.perst    = perst;
        v.seq      = 2'b00;
        v.run      = run;
        return v;
    endfunction

    task automatic chk(string name, logic [7:0] act, logic [7:0] exp);
        nChecks++;
        if (act !== exp) begin
            nFail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic chkAll(string tag, logic [7:0] st, logic [1:0] aux, logic [1:0] mainEn,
                          logic [1:0] perst, logic [1:0] seq, logic [1:0] run);
        chk({tag, ".state"}, bus.oFSM_STATE, st);
        chk({tag, ".aux"},   {6'd0, bus.oAUX_EN},  {6'd0, aux});
        chk({tag, ".main"},  {6'd0, bus.oMAIN_EN}, {6'd0, mainEn});
        chk({tag, ".perst"}, {6'd0, bus.oPERST_N}, {6'd0, perst});
        chk({tag, ".seq"},   {6'd0, bus.oSEQ_FLT}, {6'd0, seq});
        chk({tag, ".run"},   {6'd0, bus.oRUN_FLT}, {6'd0, run});
    endtask

    task automatic clk1();
        @(posedge iClk);
        #1;
    endtask

    task automatic msStep(int n);
        for (int i = 0; i < n; i++) begin
            bus.iTick_1ms = 1'b1;
            clk1();
            bus.iTick_1ms = 1'b0;
            repeat (7) clk1();
        end
    endtask

    task automatic drive(logic [1:0] prsntN, logic [1:0] pgAux, logic [1:0] edgeGood,
                         logic [1:0] nic, logic pwrEn, logic fltClr);
        bus.iPRSNT_N    = prsntN;
        bus.iPG_AUX     = pgAux;
        bus.iPWRGD_EDGE = edgeGood;
        bus.iPWRGD_NIC  = nic;
        bus.iPWR_EN_DEV = pwrEn;
        bus.iFLT_CLR    = fltClr;
    endtask

    task automatic doReset();
        iRst_n = 1'b0;
        repeat (2) clk1();
        iRst_n = 1'b1;
        clk1();
    endtask

    initial begin
        bus.iTick_1ms = 1'b0;
        drive(2'b11, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0);

        // Slot0 in low nibble; both slots walk the same power-up path.
        vecs[0]  = mk(2'b11, 1'b0, 1'b0, 0, 5,  8'h55, 2'b00, 2'b00, 2'b00, 2'b00);
        vecs[1]  = mk(2'b11, 1'b0, 1'b0, 0, 1,  8'h55, 2'b00, 2'b00, 2'b00, 2'b00);
        vecs[2]  = mk(2'b11, 1'b0, 1'b0, 0, 1,  8'h33, 2'b11, 2'b00, 2'b00, 2'b00);
        vecs[3]  = mk(2'b11, 1'b1, 1'b0, 2, 0,  8'h31, 2'b11, 2'b01, 2'b00, 2'b00);
        vecs[4]  = mk(2'b11, 1'b1, 1'b0, 0, 2,  8'h31, 2'b11, 2'b01, 2'b00, 2'b00);
        vecs[5]  = mk(2'b11, 1'b1, 1'b0, 0, 1,  8'h11, 2'b11, 2'b11, 2'b00, 2'b00);
        vecs[6]  = mk(2'b11, 1'b1, 1'b0, 0, 6,  8'h11, 2'b11, 2'b11, 2'b00, 2'b00);
        vecs[7]  = mk(2'b11, 1'b1, 1'b0, 0, 1,  8'h10, 2'b11, 2'b11, 2'b01, 2'b00);
        vecs[8]  = mk(2'b11, 1'b1, 1'b0, 0, 3,  8'h00, 2'b11, 2'b11, 2'b11, 2'b00);
        vecs[9]  = mk(2'b11, 1'b0, 1'b0, 1, 0,  8'h22, 2'b11, 2'b11, 2'b00, 2'b00);
        vecs[10] = mk(2'b11, 1'b0, 1'b0, 0, 1,  8'h33, 2'b11, 2'b00, 2'b00, 2'b00);
        vecs[11] = mk(2'b11, 1'b1, 1'b0, 1, 10, 8'h10, 2'b11, 2'b11, 2'b01, 2'b00);
        vecs[12] = mk(2'b10, 1'b1, 1'b0, 1, 0,  8'h1F, 2'b10, 2'b10, 2'b00, 2'b01);
        vecs[13] = mk(2'b00, 1'b1, 1'b1, 1, 0,  8'hF7, 2'b00, 2'b00, 2'b00, 2'b10);
        vecs[14] = mk(2'b00, 1'b1, 1'b0, 1, 0,  8'hF7, 2'b00, 2'b00, 2'b00, 2'b10);

        #5;
        iRst_n = 1'b0;
        #10;
        chkAll("reset", 8'h77, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00);
        repeat (2) clk1();
        iRst_n = 1'b1;
        clk1();

        for (int i = 0; i < 15; i++) begin
            drive(vecs[i].prsntN, vecs[i].pgAux, vecs[i].edgeGood, vecs[i].nic,
                  vecs[i].pwrEn, vecs[i].fltClr);
            repeat (vecs[i].nClk) clk1();
            msStep(vecs[i].nMs);
            chkAll($sformatf("v%0d", i), vecs[i].st, vecs[i].aux, vecs[i].mainEn,
                   vecs[i].perst, vecs[i].seq, vecs[i].run);
        end

        // Card-edge PWRGD never arrives: timeout 20 ms after entering AUX_WAIT.
        drive(2'b11, 2'b11, 2'b00, 2'b11, 1'b0, 1'b0);
        doReset();
        drive(2'b10, 2'b11, 2'b00, 2'b11, 1'b0, 1'b0);
        msStep(5);
        chkAll("to.wait", 8'h75, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00);
        msStep(19);
        chkAll("to.edge", 8'h75, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00);
        msStep(1);
        chkAll("to.fault", 8'h7F, 2'b00, 2'b00, 2'b00, 2'b01, 2'b00);
        bus.iFLT_CLR = 1'b1;
        clk1();
        bus.iFLT_CLR = 1'b0;
        chkAll("to.clr", 8'h77, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00);

        // Hot removal while in MAIN_DLY, then asynchronous reset mid-sequence.
        doReset();
        drive(2'b10, 2'b11, 2'b11, 2'b11, 1'b1, 1'b0);
        msStep(7);
        chkAll("rm.dly", 8'h71, 2'b01, 2'b01, 2'b00, 2'b00, 2'b00);
        bus.iPRSNT_N = 2'b11;
        clk1();
        chkAll("rm.gone", 8'h77, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00);
        bus.iPRSNT_N = 2'b10;
        msStep(7);
        chkAll("rst.pre", 8'h71, 2'b01, 2'b01, 2'b00, 2'b00, 2'b00);
        iRst_n = 1'b0;
        #3;
        chkAll("rst.async", 8'h77, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00);
        clk1();
        iRst_n = 1'b1;
        clk1();

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
        $finish;
    end

endmodule : tb_ocp3_nic_multi_seq
`default_nettype wire
